// File: rtl/i_mem_fill_arb_if.sv
// Request/response bundle between the fill arbiter, its two requesters and i_mem.
// The slave modport is the arbiter; the master modport is the requester/memory side.
interface i_mem_fill_arb_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              dmd_req_valid;
  logic [ADDR_W-1:0] dmd_req_addr;
  logic              dmd_req_ready;
  logic              pf_req_valid;
  logic [ADDR_W-1:0] pf_req_addr;
  logic              pf_req_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [ADDR_W-1:0] mem_rsp_addr;
  logic [LINE_W-1:0] mem_rsp_data;
  logic              dmd_rsp_valid;
  logic [LINE_W-1:0] dmd_rsp_data;
  logic              dmd_rsp_err;
  logic              pf_rsp_valid;
  logic [LINE_W-1:0] pf_rsp_data;
  logic              pf_rsp_err;
  logic              busy;
  logic              spurious_rsp;

  modport master (
    output dmd_req_valid, dmd_req_addr, pf_req_valid, pf_req_addr,
    output mem_rsp_valid, mem_rsp_addr, mem_rsp_data,
    input  dmd_req_ready, pf_req_ready, mem_req_valid, mem_req_addr,
    input  dmd_rsp_valid, dmd_rsp_data, dmd_rsp_err,
    input  pf_rsp_valid, pf_rsp_data, pf_rsp_err, busy, spurious_rsp
  );

  modport slave (
    input  dmd_req_valid, dmd_req_addr, pf_req_valid, pf_req_addr,
    input  mem_rsp_valid, mem_rsp_addr, mem_rsp_data,
    output dmd_req_ready, pf_req_ready, mem_req_valid, mem_req_addr,
    output dmd_rsp_valid, dmd_rsp_data, dmd_rsp_err,
    output pf_rsp_valid, pf_rsp_data, pf_rsp_err, busy, spurious_rsp
  );
endinterface

// File: rtl/i_mem_fill_arb.sv
// Arbitrates demand-miss and prefetch fills onto the single-outstanding i_mem port,
// merging a demand onto an in-flight prefetch of the same line.
module i_mem_fill_arb #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  i_mem_fill_arb_if.slave  bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic              owner_pf_q, owner_pf_d;
  logic              merged_q, merged_d;
  logic [LINE_W-1:0] lat_data_q, lat_data_d;
  logic              lat_err_q, lat_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              dmd_ready_s;
  logic              pf_ready_s;
  logic              rsp_match_s;

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    owner_pf_d  = owner_pf_q;
    merged_d    = merged_q;
    lat_data_d  = lat_data_q;
    lat_err_d   = lat_err_q;
    cnt_d       = cnt_q;
    dmd_ready_s = 1'b0;
    pf_ready_s  = 1'b0;
    rsp_match_s = bus.mem_rsp_valid && (bus.mem_rsp_addr == lat_addr_q);

    case (state_q)
      S_IDLE: begin
        dmd_ready_s = 1'b1;
        pf_ready_s  = !bus.dmd_req_valid;
        if (bus.dmd_req_valid) begin
          lat_addr_d = bus.dmd_req_addr;
          owner_pf_d = 1'b0;
          merged_d   = 1'b0;
          state_d    = S_ISSUE;
        end else if (bus.pf_req_valid) begin
          lat_addr_d = bus.pf_req_addr;
          owner_pf_d = 1'b1;
          merged_d   = 1'b0;
          state_d    = S_ISSUE;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A demand for the line a prefetch is already fetching rides along on it
        if (owner_pf_q && !merged_q) begin
          dmd_ready_s = (bus.dmd_req_addr == lat_addr_q);
          if (bus.dmd_req_valid && dmd_ready_s) begin
            merged_d = 1'b1;
          end else begin
            merged_d = merged_q;
          end
        end else begin
          dmd_ready_s = 1'b0;
        end
        if (rsp_match_s) begin
          lat_data_d = bus.mem_rsp_data;
          lat_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          lat_data_d = {LINE_W{1'b0}};
          lat_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          state_d    = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched-fill registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_addr_q <= {ADDR_W{1'b0}};
      owner_pf_q <= 1'b0;
      merged_q   <= 1'b0;
      lat_data_q <= {LINE_W{1'b0}};
      lat_err_q  <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      owner_pf_q <= owner_pf_d;
      merged_q   <= merged_d;
      lat_data_q <= lat_data_d;
      lat_err_q  <= lat_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.dmd_req_ready = dmd_ready_s;
  assign bus.pf_req_ready  = pf_ready_s;
  assign bus.mem_req_valid = (state_q == S_ISSUE);
  assign bus.mem_req_addr  = lat_addr_q;
  assign bus.busy          = (state_q != S_IDLE);
  // Any response not captured as the fill for lat_addr in WAIT is flagged and dropped
  assign bus.spurious_rsp  = bus.mem_rsp_valid && !((state_q == S_WAIT) && rsp_match_s);

  assign bus.dmd_rsp_valid = (state_q == S_RESP) && (!owner_pf_q || merged_q);
  assign bus.pf_rsp_valid  = (state_q == S_RESP) && owner_pf_q;
  assign bus.dmd_rsp_data  = lat_data_q;
  assign bus.pf_rsp_data   = lat_data_q;
  assign bus.dmd_rsp_err   = bus.dmd_rsp_valid && lat_err_q;
  assign bus.pf_rsp_err    = bus.pf_rsp_valid && lat_err_q;

endmodule

// File: tb/tb_i_mem_fill_arb.sv
// Bench for i_mem_fill_arb: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a timestamp-based transaction model.
module tb_i_mem_fill_arb;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i_mem_fill_arb_if #(.ADDR_W(AW), .LINE_W(LW)) ifc ();

  i_mem_fill_arb #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: one fill at a time described by when it issues and when it answers.
  bit              known = 1'b0;
  int              m_cyc = 0;
  bit              m_act = 1'b0;
  bit              m_dmd, m_merged;
  logic [AW-1:0]   m_addr, m_last;
  int              m_tiss, m_tresp;
  logic [LW-1:0]   m_data;
  bit              m_err;

  always @(negedge clk) begin
    bit in_wait, in_resp, e_dr, e_pr, e_sp;
    if (known) begin
      in_wait = m_act && (m_cyc > m_tiss) && (m_tresp < 0);
      in_resp = m_act && (m_cyc == m_tresp);
      if (!m_act) begin
        e_dr = 1'b1;
        e_pr = !ifc.dmd_req_valid;
      end else if (in_wait && !m_dmd && !m_merged) begin
        e_dr = (ifc.dmd_req_addr == m_addr);
        e_pr = 1'b0;
      end else begin
        e_dr = 1'b0;
        e_pr = 1'b0;
      end
      e_sp = ifc.mem_rsp_valid && !(in_wait && ifc.mem_rsp_addr == m_addr);
      chk("busy", ifc.busy, m_act);
      chk("mem_req_valid", ifc.mem_req_valid, m_act && (m_cyc == m_tiss));
      chk("mem_req_addr", ifc.mem_req_addr, m_last);
      chk("dmd_req_ready", ifc.dmd_req_ready, e_dr);
      chk("pf_req_ready", ifc.pf_req_ready, e_pr);
      chk("spurious_rsp", ifc.spurious_rsp, e_sp);
      chk("dmd_rsp_valid", ifc.dmd_rsp_valid, in_resp && (m_dmd || m_merged));
      chk("pf_rsp_valid", ifc.pf_rsp_valid, in_resp && !m_dmd);
      if (in_resp && (m_dmd || m_merged)) begin
        chk("dmd_rsp_data", ifc.dmd_rsp_data, m_data);
        chk("dmd_rsp_err", ifc.dmd_rsp_err, m_err);
      end
      if (in_resp && !m_dmd) begin
        chk("pf_rsp_data", ifc.pf_rsp_data, m_data);
        chk("pf_rsp_err", ifc.pf_rsp_err, m_err);
      end
    end
    if (rst) begin
      known    = 1'b1;
      m_act    = 1'b0;
      m_merged = 1'b0;
      m_last   = '0;
      m_data   = '0;
      m_err    = 1'b0;
    end else if (known) begin
      if (!m_act) begin
        if (ifc.dmd_req_valid) begin
          m_act = 1'b1; m_dmd = 1'b1; m_addr = ifc.dmd_req_addr;
        end else if (ifc.pf_req_valid) begin
          m_act = 1'b1; m_dmd = 1'b0; m_addr = ifc.pf_req_addr;
        end
        if (m_act) begin
          m_last = m_addr; m_merged = 1'b0; m_tiss = m_cyc + 1; m_tresp = -1;
        end
      end else if (m_cyc == m_tresp) begin
        m_act = 1'b0;
      end else if (m_cyc > m_tiss) begin
        if (!m_dmd && !m_merged && ifc.dmd_req_valid && ifc.dmd_req_addr == m_addr)
          m_merged = 1'b1;
        if (ifc.mem_rsp_valid && ifc.mem_rsp_addr == m_addr) begin
          m_tresp = m_cyc + 1; m_data = ifc.mem_rsp_data; m_err = 1'b0;
        end else if (m_cyc == m_tiss + TO) begin
          m_tresp = m_cyc + 1; m_data = '0; m_err = 1'b1;
        end
      end
    end
    m_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ifc.dmd_req_valid = 1'b0; ifc.dmd_req_addr = '0;
    ifc.pf_req_valid  = 1'b0; ifc.pf_req_addr  = '0;
    ifc.mem_rsp_valid = 1'b0; ifc.mem_rsp_addr = '0; ifc.mem_rsp_data = '0;
  endtask

  task automatic drive_rsp(input logic [AW-1:0] a, input logic [LW-1:0] d);
    ifc.mem_rsp_valid = 1'b1; ifc.mem_rsp_addr = a; ifc.mem_rsp_data = d;
  endtask

  initial begin
    int s;
    int sched;
    logic [AW-1:0] saddr;
    rst = 1'b1;
    idle_in();
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_mem_req_valid", ifc.mem_req_valid, 1'b0);
    chk("rst_mem_req_addr", ifc.mem_req_addr, 0);
    chk("rst_dmd_rsp_valid", ifc.dmd_rsp_valid, 1'b0);
    chk("rst_pf_rsp_valid", ifc.pf_rsp_valid, 1'b0);
    chk("rst_dmd_rsp_err", ifc.dmd_rsp_err, 1'b0);
    chk("rst_dmd_rsp_data", ifc.dmd_rsp_data, 0);
    chk("rst_pf_rsp_data", ifc.pf_rsp_data, 0);
    chk("rst_spurious", ifc.spurious_rsp, 1'b0);
    chk("rst_dmd_ready", ifc.dmd_req_ready, 1'b1);
    chk("rst_pf_ready", ifc.pf_req_ready, 1'b1);
    tick(); rst = 1'b0;

    // Single demand for line 0 (contents 1)
    ifc.dmd_req_valid = 1'b1; ifc.dmd_req_addr = 32'h0;
    tick(); ifc.dmd_req_valid = 1'b0;
    @(negedge clk);
    chk("t1_mem_req_valid", ifc.mem_req_valid, 1'b1);
    chk("t1_mem_req_addr", ifc.mem_req_addr, 0);
    tick(); drive_rsp(32'h0, 128'd1);
    tick(); ifc.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t1_dmd_rsp_valid", ifc.dmd_rsp_valid, 1'b1);
    chk("t1_dmd_rsp_data", ifc.dmd_rsp_data, 128'd1);
    chk("t1_dmd_rsp_err", ifc.dmd_rsp_err, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_busy_after", ifc.busy, 1'b0);

    // Priority, then merge onto the prefetch of 0x2
    tick();
    ifc.dmd_req_valid = 1'b1; ifc.dmd_req_addr = 32'h1;
    ifc.pf_req_valid  = 1'b1; ifc.pf_req_addr  = 32'h2;
    @(negedge clk);
    chk("pri_pf_ready", ifc.pf_req_ready, 1'b0);
    chk("pri_dmd_ready", ifc.dmd_req_ready, 1'b1);
    tick(); ifc.dmd_req_valid = 1'b0;
    @(negedge clk);
    chk("pri_first_addr", ifc.mem_req_addr, 1);
    tick(); drive_rsp(32'h1, 128'd2);
    tick(); ifc.mem_rsp_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("pri_pf_ready_idle", ifc.pf_req_ready, 1'b1);
    tick(); ifc.pf_req_valid = 1'b0;
    @(negedge clk);
    chk("pri_second_valid", ifc.mem_req_valid, 1'b1);
    chk("pri_second_addr", ifc.mem_req_addr, 2);
    tick(); ifc.dmd_req_valid = 1'b1; ifc.dmd_req_addr = 32'h3;
    @(negedge clk);
    chk("mrg_other_ready", ifc.dmd_req_ready, 1'b0);
    tick(); ifc.dmd_req_addr = 32'h2;
    @(negedge clk);
    chk("mrg_same_ready", ifc.dmd_req_ready, 1'b1);
    tick(); ifc.dmd_req_valid = 1'b0; drive_rsp(32'h2, 128'd3);
    @(negedge clk);
    chk("mrg_no_reissue", ifc.mem_req_valid, 1'b0);
    tick(); ifc.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("mrg_pf_rsp_valid", ifc.pf_rsp_valid, 1'b1);
    chk("mrg_dmd_rsp_valid", ifc.dmd_rsp_valid, 1'b1);
    chk("mrg_pf_rsp_data", ifc.pf_rsp_data, 128'd3);
    chk("mrg_dmd_rsp_data", ifc.dmd_rsp_data, 128'd3);

    // Mismatched response while waiting for 0x1
    tick(); ifc.dmd_req_valid = 1'b1; ifc.dmd_req_addr = 32'h1;
    tick(); ifc.dmd_req_valid = 1'b0;
    tick(); drive_rsp(32'h4, 128'd5);
    @(negedge clk);
    chk("sp_flag", ifc.spurious_rsp, 1'b1);
    chk("sp_busy", ifc.busy, 1'b1);
    tick(); drive_rsp(32'h1, 128'd2);
    @(negedge clk);
    chk("sp_good_flag", ifc.spurious_rsp, 1'b0);
    tick(); ifc.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("sp_rsp_valid", ifc.dmd_rsp_valid, 1'b1);
    chk("sp_rsp_data", ifc.dmd_rsp_data, 128'd2);

    // Timeout: accept at T, error response exactly at T+10
    tick(); ifc.dmd_req_valid = 1'b1; ifc.dmd_req_addr = 32'h5;
    for (int k = 1; k <= 9; k++) begin
      tick(); ifc.dmd_req_valid = 1'b0;
      @(negedge clk);
      chk("to_early_valid", ifc.dmd_rsp_valid, 1'b0);
    end
    tick();
    @(negedge clk);
    chk("to_rsp_valid", ifc.dmd_rsp_valid, 1'b1);
    chk("to_rsp_err", ifc.dmd_rsp_err, 1'b1);
    chk("to_rsp_data", ifc.dmd_rsp_data, 0);
    tick(); drive_rsp(32'h5, 128'hABCD);
    @(negedge clk);
    chk("to_late_spurious", ifc.spurious_rsp, 1'b1);
    tick(); ifc.mem_rsp_valid = 1'b0;

    // Reset while waiting for 0x6
    ifc.dmd_req_valid = 1'b1; ifc.dmd_req_addr = 32'h6;
    tick(); ifc.dmd_req_valid = 1'b0;
    tick();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; drive_rsp(32'h6, 128'h77);
    @(negedge clk);
    chk("mr_busy", ifc.busy, 1'b0);
    chk("mr_rsp_valid", ifc.dmd_rsp_valid, 1'b0);
    chk("mr_mem_req_addr", ifc.mem_req_addr, 0);
    chk("mr_late_spurious", ifc.spurious_rsp, 1'b1);
    tick(); ifc.mem_rsp_valid = 1'b0; ifc.dmd_req_valid = 1'b1; ifc.dmd_req_addr = 32'h7;
    tick(); ifc.dmd_req_valid = 1'b0;
    @(negedge clk);
    chk("mr_new_req_addr", ifc.mem_req_addr, 7);
    tick(); drive_rsp(32'h7, 128'd8);
    tick(); ifc.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("mr_new_rsp_data", ifc.dmd_rsp_data, 128'd8);
    chk("mr_new_rsp_valid", ifc.dmd_rsp_valid, 1'b1);

    // Random traffic with a reactive memory of random latency (some beyond timeout)
    s = 0;
    sched = -1;
    saddr = '0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      if (ifc.mem_req_valid) begin
        sched = s + 1 + int'($urandom_range(0, 9));
        saddr = ifc.mem_req_addr;
      end
      ifc.dmd_req_valid = ($urandom_range(0, 2) == 0);
      ifc.dmd_req_addr  = AW'($urandom_range(0, 3));
      ifc.pf_req_valid  = ($urandom_range(0, 2) == 0);
      ifc.pf_req_addr   = AW'($urandom_range(0, 3));
      if (s == sched) begin
        drive_rsp(saddr, {$urandom, $urandom, $urandom, $urandom});
      end else if ($urandom_range(0, 29) == 0) begin
        drive_rsp(AW'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom});
      end else begin
        ifc.mem_rsp_valid = 1'b0;
      end
      s++;
    end
    tick();
    rst = 1'b0;
    idle_in();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
